// File: rtl/mandel_pkg.sv
// ====================================================================
// Package : mandel_pkg
// Shared widths, pixel-field offsets and receiver state encoding.
// Rev     : 1.0
// ====================================================================
`default_nettype none

package mandel_pkg;

  localparam int COLOR_W  = 24;
  localparam int WORD_W   = 64;
  localparam int PIX0_LSB = 0;
  localparam int PIX1_LSB = 24;
  localparam int BUF_W    = 2 * COLOR_W;
  localparam int COORD_W  = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/mandel_pixel_receiver_if.sv
// ====================================================================
// Interface : mandel_pixel_receiver_if
// Packed-word input stream plus framebuffer pixel write port.
// Rev       : 1.0
// ====================================================================
`default_nettype none

interface mandel_pixel_receiver_if #(
  parameter int ADDR_W = 24
) ();
  import mandel_pkg::*;

  logic [WORD_W-1:0]  in_data;
  logic               in_single;
  logic               in_valid;
  logic               in_ready;
  logic               pix_we;
  logic               pix_stall;
  logic [COLOR_W-1:0] pix_color;
  logic [ADDR_W-1:0]  pix_addr;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               frame_done;

  // Receiver side
  modport slave (
    input  in_data, in_single, in_valid, pix_stall,
    output in_ready, pix_we, pix_color, pix_addr, pix_x, pix_y, frame_done
  );

  // Renderer / framebuffer side
  modport master (
    output in_data, in_single, in_valid, pix_stall,
    input  in_ready, pix_we, pix_color, pix_addr, pix_x, pix_y, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/mandel_raster_counter.sv
// ====================================================================
// Module : mandel_raster_counter
// Raster x/y counter with a lockstep linear address and frame wrap flag.
// Rev    : 1.0
// ====================================================================
`default_nettype none

module mandel_raster_counter
  import mandel_pkg::*;
#(
  parameter int X_SIZE = 1680,
  parameter int Y_SIZE = 1050,
  parameter int ADDR_W = 24
) (
  input  wire logic               CLK,
  input  wire logic               reset,
  input  wire logic               advance,
  output logic [COORD_W-1:0]      x,
  output logic [COORD_W-1:0]      y,
  output logic [ADDR_W-1:0]       addr,
  output logic                    wrap
);

  localparam logic [COORD_W-1:0] c_X_LAST = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] c_Y_LAST = COORD_W'(Y_SIZE - 1);

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [ADDR_W-1:0]  r_addr;
  logic               w_x_end;
  logic               w_y_end;

  assign w_x_end = (r_x == c_X_LAST);
  assign w_y_end = (r_y == c_Y_LAST);
  assign wrap    = advance && w_x_end && w_y_end;

  // Address tracks y*X_SIZE+x by counting, so no multiplier is needed
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (advance) begin
      if (w_x_end) begin
        r_x <= '0;
        if (w_y_end) begin
          r_y    <= '0;
          r_addr <= '0;
        end else begin
          r_y    <= r_y + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
      end else begin
        r_x    <= r_x + 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/mandel_pixel_receiver.sv
// ====================================================================
// Module : mandel_pixel_receiver
// Unpacks two-pixel words into a raster-addressed framebuffer write port.
// Optional frame/stall statistics ports when MANDEL_RX_STATS_EN is defined.
// Rev    : 1.0
// ====================================================================
`default_nettype none

module mandel_pixel_receiver
  import mandel_pkg::*;
#(
  parameter int X_SIZE = 1680,
  parameter int Y_SIZE = 1050,
  parameter int ADDR_W = 24
) (
  input  wire logic              CLK,
  input  wire logic              reset,
  mandel_pixel_receiver_if.slave bus
`ifdef MANDEL_RX_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [31:0]            stall_cycles
`endif
);

  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  logic [BUF_W-1:0]   r_buf;
  logic               r_single;
  logic               r_frame_done;

  logic               w_pix_we;
  logic               w_last;
  logic               w_in_ready;
  logic               w_word_xfer;
  logic               w_pix_xfer;
  logic [COLOR_W-1:0] w_color;
  logic               w_wrap;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_unused_hi;

  assign w_unused_hi = ^bus.in_data[WORD_W-1:BUF_W];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A new word may load in the same cycle the buffer's last pixel leaves
  always_comb begin
    w_pix_we    = (r_state != EMPTY);
    w_last      = (r_state == HIGH) || ((r_state == LOW) && r_single);
    w_in_ready  = (r_state == EMPTY) || (w_last && !bus.pix_stall);
    w_word_xfer = bus.in_valid && w_in_ready;
    w_pix_xfer  = w_pix_we && !bus.pix_stall;
    w_color     = '0;
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_word_xfer) begin
          w_state_nxt = LOW;
        end
      end
      LOW: begin
        w_color = r_buf[PIX0_LSB +: COLOR_W];
        if (w_pix_xfer) begin
          if (r_single) begin
            w_state_nxt = w_word_xfer ? LOW : EMPTY;
          end else begin
            w_state_nxt = HIGH;
          end
        end
      end
      HIGH: begin
        w_color = r_buf[PIX1_LSB +: COLOR_W];
        if (w_pix_xfer) begin
          w_state_nxt = w_word_xfer ? LOW : EMPTY;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_buf        <= '0;
      r_single     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_word_xfer) begin
        r_buf    <= bus.in_data[BUF_W-1:0];
        r_single <= bus.in_single;
      end
      r_frame_done <= w_wrap;
    end
  end

  mandel_raster_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .CLK     (CLK),
    .reset   (reset),
    .advance (w_pix_xfer),
    .x       (w_x),
    .y       (w_y),
    .addr    (w_addr),
    .wrap    (w_wrap)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.pix_we     = w_pix_we;
  assign bus.pix_color  = w_color;
  assign bus.pix_addr   = w_addr;
  assign bus.pix_x      = w_x;
  assign bus.pix_y      = w_y;
  assign bus.frame_done = r_frame_done;

`ifdef MANDEL_RX_STATS_EN
  logic [15:0] r_frame_count;
  logic [31:0] r_stall_cycles;

  // Frame count wraps naturally; stall count saturates at all-ones
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_frame_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (r_frame_done) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
      if (w_pix_we && bus.pix_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign frame_count  = r_frame_count;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire
